// File: rtl/alu16_pkg.sv
// alu16_pkg: shared constants and helpers for the 16-bit ALU.
// Opcode encodings, datapath width, the result bundle type and the
// signed-overflow helper used by the add/sub paths.
package alu16_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0111;
    localparam logic [3:0] OP_SWP = 4'b1000;

    // One complete ALU outcome: primary, secondary and the exception flag.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] remainder;
        logic              ovf;
    } alu16_res_t;

    localparam alu16_res_t ALU16_RES_ZERO = '{result: '0, remainder: '0, ovf: 1'b0};

    // Two's complement overflow for a + b = s: both operands share a sign
    // and the sum's sign differs from it. Subtraction reuses this by
    // passing the inverted subtrahend sign.
    function automatic logic add_ovf(input logic sign_a,
                                     input logic sign_b,
                                     input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage

// File: rtl/alu16_div.sv
// alu16_div: combinational signed 16-bit divider.
// Quotient truncates toward zero, remainder takes the dividend's sign.
// Divide-by-zero and the -32768 / -1 overflow are resolved here so the
// generic divide operators never see an operand pair they cannot represent.
// Only instantiated when ALU16_DIV_EN is defined.
module alu16_div
    import alu16_pkg::*;
(
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_exc
);

    logic w_div_zero;
    logic w_div_ovf;
    logic signed [DATA_W-1:0] w_num;
    logic signed [DATA_W-1:0] w_den;
    logic signed [DATA_W-1:0] w_quot_raw;
    logic signed [DATA_W-1:0] w_rem_raw;

    assign w_div_zero = (i_divisor == '0);
    assign w_div_ovf  = (i_dividend == {1'b1, {(DATA_W-1){1'b0}}}) &&
                        (i_divisor  == {DATA_W{1'b1}});

    // Feed a harmless divisor into the arithmetic on the special cases so
    // the raw results are always well defined; they are discarded anyway.
    assign w_num = $signed(i_dividend);
    assign w_den = (w_div_zero || w_div_ovf) ? 16'sd1 : $signed(i_divisor);

    assign w_quot_raw = w_num / w_den;
    assign w_rem_raw  = w_num % w_den;

    // Pick the architected outcome for each divisor class.
    always_comb begin
        o_quotient  = w_quot_raw;
        o_remainder = w_rem_raw;
        o_exc       = 1'b0;
        if (w_div_zero) begin
            o_quotient  = '0;
            o_remainder = i_dividend;
            o_exc       = 1'b1;
        end else if (w_div_ovf) begin
            o_quotient  = {1'b1, {(DATA_W-1){1'b0}}};
            o_remainder = '0;
            o_exc       = 1'b1;
        end
    end

endmodule

// File: rtl/alu16_core.sv
// alu16_core: 16-bit signed ALU (add, sub, mul, div, mov, swp) with one
// registered output stage and an overflow/exception flag.
// Build option ALU16_DIV_EN: when defined, opcode 0101 divides through
// alu16_div; when undefined no divider exists and 0101 reports an
// unsupported op (zero results, flag set).
module alu16_core
    import alu16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        functCode,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] remainder,
    output logic              o
);

    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [2*DATA_W-1:0] w_product;
    logic                w_mul_ovf;
    logic [DATA_W-1:0]   w_div_quot;
    logic [DATA_W-1:0]   w_div_rem;
    logic                w_div_exc;
    alu16_res_t          w_next;
    alu16_res_t          r_out;

    assign w_sum     = op1 + op2;
    assign w_diff    = op1 - op2;
    assign w_product = $signed(op1) * $signed(op2);

    // Product fits in 16 bits only when the upper 17 bits are a pure sign
    // extension.
    assign w_mul_ovf = !((&w_product[2*DATA_W-1:DATA_W-1]) ||
                         !(|w_product[2*DATA_W-1:DATA_W-1]));

`ifdef ALU16_DIV_EN
    alu16_div u_div (
        .i_dividend  (op1),
        .i_divisor   (op2),
        .o_quotient  (w_div_quot),
        .o_remainder (w_div_rem),
        .o_exc       (w_div_exc)
    );
`else
    assign w_div_quot = '0;
    assign w_div_rem  = '0;
    assign w_div_exc  = 1'b1;
`endif

    // Opcode select: build the next result bundle from the datapath taps.
    always_comb begin
        w_next = ALU16_RES_ZERO;
        case (functCode)
            OP_ADD: begin
                w_next.result = w_sum;
                w_next.ovf    = add_ovf(op1[DATA_W-1], op2[DATA_W-1], w_sum[DATA_W-1]);
            end
            OP_SUB: begin
                w_next.result = w_diff;
                w_next.ovf    = add_ovf(op1[DATA_W-1], ~op2[DATA_W-1], w_diff[DATA_W-1]);
            end
            OP_MUL: begin
                w_next.result    = w_product[DATA_W-1:0];
                w_next.remainder = w_product[2*DATA_W-1:DATA_W];
                w_next.ovf       = w_mul_ovf;
            end
            OP_DIV: begin
                w_next.result    = w_div_quot;
                w_next.remainder = w_div_rem;
                w_next.ovf       = w_div_exc;
            end
            OP_MOV: begin
                w_next.result = op1;
            end
            OP_SWP: begin
                w_next.result    = op1;
                w_next.remainder = op2;
            end
            default: begin
                w_next = ALU16_RES_ZERO;
            end
        endcase
    end

    // Output register stage; reset takes priority over any opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= ALU16_RES_ZERO;
        end else begin
            r_out <= w_next;
        end
    end

    assign result    = r_out.result;
    assign remainder = r_out.remainder;
    assign o         = r_out.ovf;

endmodule

// File: tb/tb_alu16_core.sv
// tb_alu16_core: self-checking bench for alu16_core.
// Expected values come from an integer-arithmetic reference model of the
// opcode rules; DIV expectations follow whether ALU16_DIV_EN is defined.
module tb_alu16_core;

    logic        clk;
    logic        rst;
    logic [3:0]  functCode;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        o;

    int n_checks;
    int n_fails;

    alu16_core dut (
        .clk       (clk),
        .rst       (rst),
        .functCode (functCode),
        .op1       (op1),
        .op2       (op2),
        .result    (result),
        .remainder (remainder),
        .o         (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference model: returns {ovf, remainder[15:0], result[15:0]}.
    function automatic logic [32:0] model(input logic [3:0] f, input logic [15:0] a16, input logic [15:0] b16);
        int a;
        int b;
        int r;
        int m;
        bit ov;
        a  = int'($signed(a16));
        b  = int'($signed(b16));
        r  = 0;
        m  = 0;
        ov = 1'b0;
        case (f)
            4'b0000: begin r = a + b; ov = (r > 32767) || (r < -32768); end
            4'b0001: begin r = a - b; ov = (r > 32767) || (r < -32768); end
            4'b0100: begin
                r  = a * b;
                m  = r >>> 16;
                ov = (r > 32767) || (r < -32768);
            end
            4'b0101: begin
`ifdef ALU16_DIV_EN
                if (b == 0) begin
                    r = 0; m = a; ov = 1'b1;
                end else if (a == -32768 && b == -1) begin
                    r = -32768; m = 0; ov = 1'b1;
                end else begin
                    r = a / b; m = a % b;
                end
`else
                ov = 1'b1;
`endif
            end
            4'b0111: r = a;
            4'b1000: begin r = a; m = b; end
            default: ;
        endcase
        return {ov, m[15:0], r[15:0]};
    endfunction

    // Apply one operation, then scramble the inputs after the edge so the
    // check only passes if the outputs were captured at that edge.
    task automatic do_op(input string tag, input logic r, input logic [3:0] f,
                         input logic [15:0] a, input logic [15:0] b);
        logic [32:0] exp_v;
        @(negedge clk);
        rst       = r;
        functCode = f;
        op1       = a;
        op2       = b;
        exp_v     = r ? 33'd0 : model(f, a, b);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        functCode = 4'($urandom);
        op1       = 16'($urandom);
        op2       = 16'($urandom);
        #1;
        check({tag, ".result"},    32'(result),    32'(exp_v[15:0]));
        check({tag, ".remainder"}, 32'(remainder), 32'(exp_v[31:16]));
        check({tag, ".o"},         32'(o),         32'(exp_v[32]));
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        functCode = 4'h0;
        op1       = 16'h0;
        op2       = 16'h0;

        for (int i = 0; i < 2; i++)
            do_op("reset", 1'b1, 4'($urandom), 16'($urandom), 16'($urandom));

        vecs.push_back('{"add_basic", 4'b0000, 16'h1111, 16'h8888});
        vecs.push_back('{"add_ovf",   4'b0000, 16'h7FFF, 16'h0001});
        vecs.push_back('{"add_negovf",4'b0000, 16'h8000, 16'hFFFF});
        vecs.push_back('{"sub_ovf",   4'b0001, 16'h8000, 16'h0001});
        vecs.push_back('{"sub_basic", 4'b0001, 16'h0005, 16'h0007});
        vecs.push_back('{"mul_small", 4'b0100, 16'h0001, 16'h0003});
        vecs.push_back('{"mul_ovf",   4'b0100, 16'h0100, 16'h0100});
        vecs.push_back('{"mul_neg",   4'b0100, 16'hFFFF, 16'h0005});
        vecs.push_back('{"mul_edge",  4'b0100, 16'h8000, 16'hFFFF});
        vecs.push_back('{"div_neg",   4'b0101, 16'hFFF9, 16'h0002});
        vecs.push_back('{"div_zero",  4'b0101, 16'h1234, 16'h0000});
        vecs.push_back('{"div_ovf",   4'b0101, 16'h8000, 16'hFFFF});
        vecs.push_back('{"div_pos",   4'b0101, 16'h0064, 16'hFFF9});
        vecs.push_back('{"mov",       4'b0111, 16'hBEEF, 16'h1234});
        vecs.push_back('{"swp",       4'b1000, 16'hAAAA, 16'h5555});
        vecs.push_back('{"nop_f",     4'b1111, 16'h1234, 16'h5678});
        vecs.push_back('{"nop_2",     4'b0010, 16'h7FFF, 16'h7FFF});

        foreach (vecs[i])
            do_op(vecs[i].tag, 1'b0, vecs[i].f, vecs[i].a, vecs[i].b);

        // Back-to-back random stream with occasional mid-stream resets.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] f;
            case ($urandom_range(0, 7))
                0: f = 4'b0000;
                1: f = 4'b0001;
                2: f = 4'b0100;
                3: f = 4'b0101;
                4: f = 4'b0111;
                5: f = 4'b1000;
                default: f = 4'($urandom);
            endcase
            do_op("rand", ($urandom_range(0, 19) == 0), f,
                  16'($urandom), ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom));
        end

        do_op("pre_rst",  1'b0, 4'b0000, 16'h7FFF, 16'h0001);
        do_op("mid_rst",  1'b1, 4'b1000, 16'hAAAA, 16'h5555);
        do_op("post_rst", 1'b0, 4'b0100, 16'h0100, 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
